// File: rtl/sensor_scan_pkg.sv
// Shared definitions for the sensor scan sequencer: register map, bit
// positions inside CTRL/STATUS, and the scan FSM state encoding.
package sensor_scan_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_FCNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SETTLE,
    SAMPLE
  } scan_state_e;

endpackage

// File: rtl/sensor_scan_ctrl_if.sv
// Avalon-MM register port of the sensor scan sequencer; the Nios side is the
// master, the sequencer register file is the slave.
interface sensor_scan_ctrl_if;

  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output write, output writedata, input readdata);
  modport slave  (input address, input write, input writedata, output readdata);

endinterface

// File: rtl/sensor_scan_ctrl_sync_2ff.sv
// Generic multi-bit 2-flop synchronizer for slowly changing sensor words that
// are only sampled long after they have settled.
module sync_2ff #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sensor_scan_ctrl.sv
// Scan sequencer: steps the external mux over the sensor banks, waits for the
// input to settle, captures each bank into a shadow register readable over Avalon.
module sensor_scan_ctrl
  import sensor_scan_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DATA_W        = 9,
  parameter int SETTLE_CYCLES = 50
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] sens_in,
  output logic [1:0]        sel_out,
  output logic              irq,
  sensor_scan_ctrl_if.slave bus
);

  localparam int              CNT_W    = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]      LAST_CH  = 2'(NUM_CH - 1);
  localparam logic [2:0]      NUM_CH_A = 3'(NUM_CH);

  scan_state_e       state_d, state_q;
  logic [1:0]        ch_d, ch_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [1:0]        sel_d, sel_q;
  logic [1:0]        ctrl_d, ctrl_q;
  logic              done_d, done_q;
  logic [7:0]        frame_cnt_d, frame_cnt_q;
  logic [31:0]       readdata_d, readdata_q;
  logic              irq_d, irq_q;
  logic [DATA_W-1:0] shadow_d [NUM_CH];
  logic [DATA_W-1:0] shadow_q [NUM_CH];
  logic [DATA_W-1:0] sens_sync;
  logic              busy;
  logic              unused_wdata;

  assign unused_wdata = ^bus.writedata[31:2];

  sync_2ff #(.WIDTH(DATA_W)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (sens_in),
    .q       (sens_sync)
  );

  // Register writes are applied before the FSM so a done set in SAMPLE
  // overrides a simultaneous write-1-to-clear.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    ctrl_d      = ctrl_q;
    done_d      = done_q;
    frame_cnt_d = frame_cnt_q;
    for (int i = 0; i < NUM_CH; i++) shadow_d[i] = shadow_q[i];
    busy = (state_q != IDLE);

    if (bus.write) begin
      if (bus.address == ADDR_CTRL) begin
        ctrl_d = bus.writedata[1:0];
      end else if (bus.address == ADDR_STATUS && bus.writedata[STAT_DONE]) begin
        done_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (ctrl_q[CTRL_RUN]) begin
          ch_d    = 2'd0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        sel_d   = ch_q;
        cnt_d   = CNT_LOAD;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      SAMPLE: begin
        shadow_d[ch_q] = sens_sync;
        if (ch_q != LAST_CH) begin
          ch_d    = ch_q + 2'd1;
          state_d = SELECT;
        end else begin
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
          ch_d        = 2'd0;
          state_d     = ctrl_q[CTRL_RUN] ? SELECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    readdata_d = '0;
    if (bus.address < NUM_CH_A) begin
      readdata_d[DATA_W-1:0] = shadow_q[bus.address[1:0]];
    end else if (bus.address == ADDR_CTRL) begin
      readdata_d[1:0] = ctrl_q;
    end else if (bus.address == ADDR_STATUS) begin
      readdata_d[STAT_BUSY]              = busy;
      readdata_d[STAT_DONE]              = done_q;
      readdata_d[STAT_FCNT_LSB +: 8]     = frame_cnt_q;
    end

    irq_d = done_q & ctrl_q[CTRL_IRQ_EN];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      ctrl_q      <= '0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      ctrl_q      <= ctrl_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  assign sel_out      = sel_q;
  assign irq          = irq_q;
  assign bus.readdata = readdata_q;

endmodule

// File: doc/sensor_scan_ctrl.md
Name: sensor_scan_ctrl

Overview:
Scan sequencer for the multiplexed line-sensor banks that share one 9-bit sensor input path. It drives the external mux select, waits a programmable settle time, and captures each bank into its own shadow register. The Nios reads the shadow registers over an Avalon-MM slave. The block replaces per-bank PIO inputs with one scheduled, shared input and raises an end-of-frame interrupt.

Parameters:
NUM_CH, 4, number of sensor banks scanned (2..4)
DATA_W, 9, sensor word width (1..16)
SETTLE_CYCLES, 50, clk cycles held in SETTLE after each select change (>=3, covers the 2-flop synchronizer)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
sens_in  in  DATA_W  muxed sensor data, asynchronous to clk
sel_out  out  2  external mux select (bank index)
address  in  3  Avalon word address
write  in  1  Avalon write strobe
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
irq  out  1  level interrupt to Nios

Behaviour:
- Reset: sel_out=0, readdata=0, irq=0, all shadow registers=0, ctrl=0, done=0, frame_cnt=0, FSM=IDLE, synchronizer flops=0.
- sens_in passes through a 2-flop synchronizer; only the synchronized value is sampled.
- Register map:
  - 0..NUM_CH-1: shadow data, zero-extended, RO.
  - 4: CTRL. bit0 run, bit1 irq_en. RW.
  - 5: STATUS. bit0 busy, bit1 done (sticky, write 1 to clear), bits[15:8] frame_cnt. RO except the done clear.
  - Other addresses, and unused data slots: read 0, writes ignored.
- readdata is updated every clk from the address decode; latency is 1 cycle; there is no read strobe and reads have no side effects.
- FSM states: IDLE, SELECT, SETTLE, SAMPLE.
  - IDLE: busy=0. If run=1, go to SELECT with ch=0.
  - SELECT (1 cycle): sel_out<=ch; settle counter<=SETTLE_CYCLES-1.
  - SETTLE: count down; at 0 go to SAMPLE. Duration is exactly SETTLE_CYCLES cycles.
  - SAMPLE (1 cycle): shadow[ch]<=synchronized sens_in.
    - If ch<NUM_CH-1: ch<=ch+1, go to SELECT.
    - Otherwise: done<=1, frame_cnt<=frame_cnt+1 (wraps 255->0); go to SELECT with ch=0 if run=1, else IDLE.
- Timing: each channel takes SETTLE_CYCLES+2 cycles. A frame takes NUM_CH*(SETTLE_CYCLES+2) cycles. The first SELECT is the cycle after run is seen as 1.
- busy=1 in every state except IDLE.
- Clearing run mid-frame: the current frame completes and updates all channels, then the FSM enters IDLE. A frame is never truncated.
- Setting run again while finishing a frame: scanning continues seamlessly.
- A write-1-to-clear of done in the same cycle that SAMPLE sets done: set wins, done stays 1.
- irq = done & irq_en, registered (1-cycle delay). Clearing irq_en drops irq without clearing done.
- A shadow register changes only in its own SAMPLE cycle, so a read never returns a partially updated word.
- reset_n asserted mid-frame: immediate return to reset values. No frame completion, no done.

Decomposition:
- Shared package sensor_scan_pkg:
  - register address constants ADDR_CTRL=4, ADDR_STATUS=5
  - CTRL/STATUS bit indices
  - FSM state enum (IDLE, SELECT, SETTLE, SAMPLE)
- One natural sub-module, sync_2ff (DATA_W-wide 2-flop synchronizer), reusable by the other sensor paths.
- Everything else is inline: FSM, counters, register file.

Test Plan:
(All scenarios use NUM_CH=4, SETTLE_CYCLES=4, so 6 cycles per channel and 24 cycles per frame.)
1. Reset, then read addresses 0..5 and 7 -> all read 0x0 one cycle after the address; sel_out=0; irq=0.
2. Hold sens_in per bank (sel 0→0x1A5, 1→0x0FF, 2→0x100, 3→0x001); write CTRL=0x1 -> sel_out steps 0,1,2,3 every 6 cycles. After 24 cycles, addresses 0..3 read 0x1A5, 0x0FF, 0x100, 0x001. STATUS reads 0x0103 (frame_cnt=1, done=1, busy=1).
3. Write CTRL=0x3 and let a frame complete -> irq rises 1 cycle after done. Write STATUS=0x2 -> done=0 and irq falls next cycle. Force the clear write into the SAMPLE cycle of ch3 -> done stays 1.
4. Write CTRL=0x0 at cycle 8 of a frame -> remaining channels are still sampled; FSM reaches IDLE after the frame; busy=0; frame_cnt incremented exactly once; sel_out holds 3.
5. Run 256 frames continuously -> frame_cnt wraps from 0xFF to 0x00; done stays sticky at 1.
6. Pulse reset_n low during SETTLE of ch2 -> readdata, shadows, sel_out, CTRL and STATUS all return to 0 at once. After release, nothing is scanned until run is rewritten.
